// File: rtl/demux1to2_l2.sv
// Layer-2 de-interleaver: rebuilds two parallel 8-bit lanes from an alternating slot stream.
// Optional macro DEMUX_L2_ZERO_INVALID_EN: invalid lanes load 8'h00 on commit instead of holding.
//
// r_slot | meaning
// -------+-------------------------------------------------
//   0    | next edge captures slot 0 into the hold register
//   1    | next edge commits hold + slot 1 to both lanes
module demux1to2_l2 #(
  parameter int unsigned FIRST_LANE = 0,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [7:0]         data_in,
  input  logic               valid_in,
  output logic [7:0]         data_out0,
  output logic [7:0]         data_out1,
  output logic               valid_out0,
  output logic               valid_out1,
  output logic [COUNT_W-1:0] pair_count
);

  localparam bit SWAP = (FIRST_LANE != 0);

  logic               r_slot;
  logic [7:0]         r_hold_data;
  logic               r_hold_valid;
  logic [7:0]         r_data_out0;
  logic [7:0]         r_data_out1;
  logic               r_valid_out0;
  logic               r_valid_out1;
  logic [COUNT_W-1:0] r_pair_count;

  logic [7:0]         w_lane0_data;
  logic [7:0]         w_lane1_data;
  logic               w_lane0_valid;
  logic               w_lane1_valid;
  logic               w_commit;

  assign w_commit = r_slot;

  // Slot 0 (held) goes to lane FIRST_LANE; the live slot 1 goes to the other lane.
  always_comb begin
    w_lane0_data  = r_hold_data;
    w_lane0_valid = r_hold_valid;
    w_lane1_data  = data_in;
    w_lane1_valid = valid_in;
    if (SWAP) begin
      w_lane0_data  = data_in;
      w_lane0_valid = valid_in;
      w_lane1_data  = r_hold_data;
      w_lane1_valid = r_hold_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_slot       <= 1'b0;
      r_hold_data  <= 8'h00;
      r_hold_valid <= 1'b0;
    end else begin
      r_slot <= ~r_slot;
      if (!w_commit) begin
        r_hold_data  <= data_in;
        r_hold_valid <= valid_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data_out0  <= 8'h00;
      r_data_out1  <= 8'h00;
      r_valid_out0 <= 1'b0;
      r_valid_out1 <= 1'b0;
      r_pair_count <= '0;
    end else if (w_commit) begin
      r_valid_out0 <= w_lane0_valid;
      r_valid_out1 <= w_lane1_valid;
      if (w_lane0_valid)
        r_data_out0 <= w_lane0_data;
`ifdef DEMUX_L2_ZERO_INVALID_EN
      else
        r_data_out0 <= 8'h00;
`endif
      if (w_lane1_valid)
        r_data_out1 <= w_lane1_data;
`ifdef DEMUX_L2_ZERO_INVALID_EN
      else
        r_data_out1 <= 8'h00;
`endif
      if (w_lane0_valid || w_lane1_valid)
        r_pair_count <= r_pair_count + COUNT_W'(1);
    end
  end

  assign data_out0  = r_data_out0;
  assign data_out1  = r_data_out1;
  assign valid_out0 = r_valid_out0;
  assign valid_out1 = r_valid_out1;
  assign pair_count = r_pair_count;

endmodule

// File: tb/tb_demux1to2_l2.sv
// Bench for demux1to2_l2: three instances (straight, swapped lanes, 2-bit counter)
// compared against a beat-queue reference model under directed and random streams.
module tb_demux1to2_l2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;

  logic [2:0][7:0] od0, od1;
  logic [2:0]      ov0, ov1;
  logic [7:0]      oc0, oc1;
  logic [1:0]      oc2;

  demux1to2_l2 #(.FIRST_LANE(0), .COUNT_W(8)) u_dut_a (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .data_out0(od0[0]), .data_out1(od1[0]), .valid_out0(ov0[0]), .valid_out1(ov1[0]),
    .pair_count(oc0));

  demux1to2_l2 #(.FIRST_LANE(1), .COUNT_W(8)) u_dut_b (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .data_out0(od0[1]), .data_out1(od1[1]), .valid_out0(ov0[1]), .valid_out1(ov1[1]),
    .pair_count(oc1));

  demux1to2_l2 #(.FIRST_LANE(0), .COUNT_W(2)) u_dut_c (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .data_out0(od0[2]), .data_out1(od1[2]), .valid_out0(ov0[2]), .valid_out1(ov1[2]),
    .pair_count(oc2));

  int total = 0;
  int bad   = 0;

  int fl[3]   = '{0, 1, 0};
  int cmod[3] = '{256, 256, 4};

  logic [7:0] ed0[3], ed1[3];
  logic       ev0[3], ev1[3];
  int         ecnt[3];
  logic [8:0] beat_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    beat_q.delete();
    for (int i = 0; i < 3; i++) begin
      ed0[i] = 8'h00; ed1[i] = 8'h00;
      ev0[i] = 1'b0;  ev1[i] = 1'b0;
      ecnt[i] = 0;
    end
  endtask

  // Every second beat since reset forms a pair: first beat -> lane fl, second -> the other.
  task automatic model_beat(input logic [7:0] d, input logic v);
    logic [8:0] b0, b1;
    logic [7:0] ld[2];
    logic       lv[2];
    beat_q.push_back({v, d});
    if (beat_q.size() == 2) begin
      b0 = beat_q.pop_front();
      b1 = beat_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        ld[fl[i]]     = b0[7:0]; lv[fl[i]]     = b0[8];
        ld[1 - fl[i]] = b1[7:0]; lv[1 - fl[i]] = b1[8];
        ev0[i] = lv[0];
        ev1[i] = lv[1];
`ifdef DEMUX_L2_ZERO_INVALID_EN
        ed0[i] = lv[0] ? ld[0] : 8'h00;
        ed1[i] = lv[1] ? ld[1] : 8'h00;
`else
        if (lv[0]) ed0[i] = ld[0];
        if (lv[1]) ed1[i] = ld[1];
`endif
        if (lv[0] || lv[1]) ecnt[i] = (ecnt[i] + 1) % cmod[i];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] c;
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 32'(oc0) : (i == 1) ? 32'(oc1) : 32'(oc2);
      chk($sformatf("%s.u%0d.data_out0", tag, i), 32'(od0[i]), 32'(ed0[i]));
      chk($sformatf("%s.u%0d.data_out1", tag, i), 32'(od1[i]), 32'(ed1[i]));
      chk($sformatf("%s.u%0d.valid_out0", tag, i), 32'(ov0[i]), 32'(ev0[i]));
      chk($sformatf("%s.u%0d.valid_out1", tag, i), 32'(ov1[i]), 32'(ev1[i]));
      chk($sformatf("%s.u%0d.pair_count", tag, i), c, 32'(ecnt[i]));
    end
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
    model_beat(d, v);
    check_all(tag);
  endtask

  // Called just after a clock edge; asserts reset mid-cycle and checks the async clear.
  task automatic async_reset(input string tag, input int hold);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    for (int k = 0; k < hold; k++) begin
      data_in  = 8'($urandom);
      valid_in = 1'($urandom);
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
    end
    reset_L = 1'b1;
  endtask

  logic [7:0] rd;
  logic       rv;

  initial begin
    reset_L  = 1'b0;
    data_in  = 8'hFF;
    valid_in = 1'b1;
    model_reset();
    #1;
    check_all("rst_hold");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    reset_L = 1'b1;

    step("basic", 8'h01, 1'b1);
    step("basic", 8'h02, 1'b1);
    chk("basic.pair1.d0", 32'(od0[0]), 32'h01);
    chk("basic.pair1.d1", 32'(od1[0]), 32'h02);
    step("basic", 8'h0A, 1'b1);
    chk("basic.hold.d0", 32'(od0[0]), 32'h01);
    step("basic", 8'h0B, 1'b1);
    step("basic", 8'h05, 1'b1);
    step("basic", 8'h06, 1'b1);
    chk("basic.pair3.d0", 32'(od0[0]), 32'h05);
    chk("basic.pair3.d1", 32'(od1[0]), 32'h06);
    chk("basic.count", 32'(oc0), 32'd3);

    step("swap", 8'hFF, 1'b1);
    step("swap", 8'hAA, 1'b1);
    chk("swap.d1", 32'(od1[1]), 32'hFF);
    chk("swap.d0", 32'(od0[1]), 32'hAA);

    step("inval", 8'h09, 1'b1);
    step("inval", 8'h01, 1'b1);
    step("inval", 8'hF1, 1'b0);
    step("inval", 8'hA2, 1'b1);
    chk("inval.v0", 32'(ov0[0]), 32'd0);
    chk("inval.v1", 32'(ov1[0]), 32'd1);
    chk("inval.d1", 32'(od1[0]), 32'hA2);
`ifdef DEMUX_L2_ZERO_INVALID_EN
    chk("inval.d0", 32'(od0[0]), 32'h00);
`else
    chk("inval.d0", 32'(od0[0]), 32'h09);
`endif
    step("both_inval", 8'h3C, 1'b0);
    step("both_inval", 8'hC3, 1'b0);
    chk("both_inval.v0", 32'(ov0[0]), 32'd0);
    chk("both_inval.v1", 32'(ov1[0]), 32'd0);
    chk("both_inval.count", 32'(oc0), 32'd6);

    step("midpair", 8'h33, 1'b1);
    async_reset("midpair", 1);
    step("midpair", 8'h44, 1'b1);
    step("midpair", 8'h55, 1'b1);
    chk("midpair.d0", 32'(od0[0]), 32'h44);
    chk("midpair.d1", 32'(od1[0]), 32'h55);

    async_reset("wrap_pre", 0);
    for (int p = 0; p < 5; p++) begin
      step("wrap", 8'($urandom), 1'b1);
      step("wrap", 8'($urandom), 1'b1);
      chk($sformatf("wrap.count%0d", p), 32'(oc2), 32'((p + 1) % 4));
    end

    for (int k = 0; k < 600; k++) begin
      rd = 8'($urandom);
      rv = ($urandom_range(0, 9) < 7);
      step("rand", rd, rv);
      if ($urandom_range(0, 49) == 0)
        async_reset("rand_rst", int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
